logical_tile_io_bank: RTL and testbench

- Parametrised multi-pad IO tile. It replaces single-pad, bl/wl-configured IO tiles with a bank of NUM_PADS pads.
- Per-pad mode (registered or bypass in each direction, A2F inversion) is held in a serial configuration chain. A completion counter reports when the chain is fully loaded.
- The pad data flops form a scan chain.
- Sits between the QL_PREIO pad ring and fabric routing; one instance per IO grid tile.

---
 rtl/io_bank_pkg.sv | 20 ++
 rtl/io_bank_cfg_chain.sv | 57 +++++
 rtl/logical_tile_io_bank.sv | 92 +++++++++
 tb/tb_logical_tile_io_bank.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_bank_pkg.sv
// Shared constants and types for the multi-pad IO bank tile.
// Per-pad configuration is three bits: A2F register, F2A register, A2F invert.
package io_bank_pkg;

    localparam int CFG_BITS_PER_PAD = 3;
    localparam int A2F_REG_BIT      = 0;
    localparam int F2A_REG_BIT      = 1;
    localparam int A2F_INV_BIT      = 2;

    function automatic int cfg_w(input int n);
        return CFG_BITS_PER_PAD * n;
    endfunction

    typedef struct packed {
        logic a2f_inv;
        logic f2a_reg;
        logic a2f_reg;
    } pad_cfg_t;

endpackage

// File: rtl/io_bank_cfg_chain.sv
// Serial configuration shift register with a burst-length counter
// that flags when a complete bitstream has been shifted in.
module io_bank_cfg_chain
    import io_bank_pkg::*;
#(
    parameter int NUM_PADS = 4,
    localparam int CFG_W = cfg_w(NUM_PADS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             config_en,
    input  logic             ccff_head,
    output logic             ccff_tail,
    output logic             config_loaded,
    output logic [CFG_W-1:0] cfg_o
);

    localparam int CNT_W = $clog2(CFG_W + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CFG_W);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CFG_W-1:0] cfg_q, cfg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             en_prev_q, en_prev_d;

    always_comb begin
        cfg_d     = cfg_q;
        cnt_d     = cnt_q;
        en_prev_d = config_en;
        if (config_en) begin
            cfg_d = {cfg_q[CFG_W-2:0], ccff_head};
            // A fresh burst restarts the count; a continuing one saturates.
            if (!en_prev_q) begin
                cnt_d = CNT_ONE;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_q     <= '0;
            cnt_q     <= '0;
            en_prev_q <= 1'b0;
        end else begin
            cfg_q     <= cfg_d;
            cnt_q     <= cnt_d;
            en_prev_q <= en_prev_d;
        end
    end

    assign cfg_o         = cfg_q;
    assign ccff_tail     = cfg_q[CFG_W-1];
    assign config_loaded = (cnt_q == CNT_MAX) && !config_en;

endmodule

// File: rtl/logical_tile_io_bank.sv
// Bank of NUM_PADS IO pads with per-pad registered/bypass modes,
// serial configuration and a scan chain through the pad data flops.
module logical_tile_io_bank
    import io_bank_pkg::*;
#(
    parameter int NUM_PADS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                config_en,
    input  logic                ccff_head,
    output logic                ccff_tail,
    output logic                config_loaded,
    input  logic                scan_en,
    input  logic                io_sc_in,
    output logic                io_sc_out,
    input  logic [NUM_PADS-1:0] gfpga_pad_QL_PREIO_A2F,
    output logic [NUM_PADS-1:0] gfpga_pad_QL_PREIO_F2A,
    input  logic [NUM_PADS-1:0] io_f2a_i,
    output logic [NUM_PADS-1:0] io_a2f_o
);

    localparam int CFG_W = cfg_w(NUM_PADS);

    logic [CFG_W-1:0]    cfg;
    logic [NUM_PADS-1:0] a2f_q, a2f_d;
    logic [NUM_PADS-1:0] f2a_q, f2a_d;
    logic [NUM_PADS-1:0] raw;
    logic [NUM_PADS-1:0] sc_src;

    io_bank_cfg_chain #(
        .NUM_PADS(NUM_PADS)
    ) u_cfg (
        .clk          (clk),
        .reset        (reset),
        .config_en    (config_en),
        .ccff_head    (ccff_head),
        .ccff_tail    (ccff_tail),
        .config_loaded(config_loaded),
        .cfg_o        (cfg)
    );

    for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
        localparam int BASE = CFG_BITS_PER_PAD * p;
        pad_cfg_t pcfg;

        assign pcfg.a2f_reg = cfg[BASE + A2F_REG_BIT];
        assign pcfg.f2a_reg = cfg[BASE + F2A_REG_BIT];
        assign pcfg.a2f_inv = cfg[BASE + A2F_INV_BIT];

        assign raw[p] = gfpga_pad_QL_PREIO_A2F[p] ^ pcfg.a2f_inv;

        // Scan order walks a2f then f2a of each pad in turn.
        if (p == 0) begin : g_head
            assign sc_src[p] = io_sc_in;
        end else begin : g_link
            assign sc_src[p] = f2a_q[p-1];
        end

        assign io_a2f_o[p] = !config_en &
            (pcfg.a2f_reg ? a2f_q[p] : raw[p]);
        assign gfpga_pad_QL_PREIO_F2A[p] = !config_en &
            (pcfg.f2a_reg ? f2a_q[p] : io_f2a_i[p]);
    end

    always_comb begin
        a2f_d = a2f_q;
        f2a_d = f2a_q;
        if (!config_en) begin
            if (scan_en) begin
                a2f_d = sc_src;
                f2a_d = a2f_q;
            end else begin
                a2f_d = raw;
                f2a_d = io_f2a_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a2f_q <= '0;
            f2a_q <= '0;
        end else begin
            a2f_q <= a2f_d;
            f2a_q <= f2a_d;
        end
    end

    assign io_sc_out = f2a_q[NUM_PADS-1];

endmodule

// File: tb/tb_logical_tile_io_bank.sv
// Randomised and directed checks of logical_tile_io_bank against a
// behavioural model built from bit history, burst length and a scan list.
module tb_logical_tile_io_bank;

    localparam int N = 4;
    localparam int W = 3 * N;
    localparam int OW = 2 * N + 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         config_en;
    logic         ccff_head;
    logic         ccff_tail;
    logic         config_loaded;
    logic         scan_en;
    logic         io_sc_in;
    logic         io_sc_out;
    logic [N-1:0] pad_a2f;
    logic [N-1:0] f2a_o;
    logic [N-1:0] io_f2a_i;
    logic [N-1:0] io_a2f_o;
    logic [OW-1:0] obs;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: bits shifted in, current burst length, scan-ordered flops.
    bit hist[$];
    int burst;
    bit en_prev;
    bit chain[2*N];

    always #5 clk = ~clk;

    logical_tile_io_bank #(.NUM_PADS(N)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .config_en             (config_en),
        .ccff_head             (ccff_head),
        .ccff_tail             (ccff_tail),
        .config_loaded         (config_loaded),
        .scan_en               (scan_en),
        .io_sc_in              (io_sc_in),
        .io_sc_out             (io_sc_out),
        .gfpga_pad_QL_PREIO_A2F(pad_a2f),
        .gfpga_pad_QL_PREIO_F2A(f2a_o),
        .io_f2a_i              (io_f2a_i),
        .io_a2f_o              (io_a2f_o)
    );

    assign obs = {io_a2f_o, f2a_o, ccff_tail, config_loaded, io_sc_out};

    function automatic bit cfg_bit(input int i);
        if (i < hist.size()) return hist[hist.size() - 1 - i];
        return 1'b0;
    endfunction

    function automatic logic [N-1:0] exp_a2f();
        logic [N-1:0] r;
        for (int p = 0; p < N; p++) begin
            if (config_en) r[p] = 1'b0;
            else if (cfg_bit(3*p)) r[p] = chain[2*p];
            else r[p] = pad_a2f[p] ^ cfg_bit(3*p+2);
        end
        return r;
    endfunction

    function automatic logic [N-1:0] exp_f2a();
        logic [N-1:0] r;
        for (int p = 0; p < N; p++) begin
            if (config_en) r[p] = 1'b0;
            else if (cfg_bit(3*p+1)) r[p] = chain[2*p+1];
            else r[p] = io_f2a_i[p];
        end
        return r;
    endfunction

    function automatic logic [OW-1:0] exp_vec();
        logic ld;
        ld = (burst >= W) && !config_en;
        return {exp_a2f(), exp_f2a(), cfg_bit(W-1), ld, chain[2*N-1]};
    endfunction

    function automatic void model_step();
        bit nxt[2*N];
        if (reset) begin
            hist.delete();
            burst   = 0;
            en_prev = 1'b0;
            for (int i = 0; i < 2*N; i++) chain[i] = 1'b0;
            return;
        end
        nxt = chain;
        if (config_en) begin
            hist.push_back(ccff_head);
            if (hist.size() > W) void'(hist.pop_front());
            burst = en_prev ? burst + 1 : 1;
        end else if (scan_en) begin
            nxt[0] = io_sc_in;
            for (int i = 1; i < 2*N; i++) nxt[i] = chain[i-1];
        end else begin
            for (int p = 0; p < N; p++) begin
                nxt[2*p]   = pad_a2f[p] ^ cfg_bit(3*p+2);
                nxt[2*p+1] = io_f2a_i[p];
            end
        end
        chain   = nxt;
        en_prev = config_en;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic load_cfg(input logic [W-1:0] v);
        config_en = 1'b1;
        for (int k = 0; k < W; k++) begin
            ccff_head = v[W-1-k];
            tick();
        end
        config_en = 1'b0;
        ccff_head = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; config_en = 1'b1; scan_en = 1'b1;
        ccff_head = 1'b1; io_sc_in = 1'b1;
        pad_a2f = 4'b1010; io_f2a_i = 4'b0110;
        tick();
        tick();
        config_en = 1'b0; scan_en = 1'b0;
        #2;
        n_cmp++;
        if (obs !== {4'b1010, 4'b0110, 3'b000}) begin
            n_bad++;
            $display("FAIL reset_state: got %b want %b",
                obs, {4'b1010, 4'b0110, 3'b000});
        end
        reset = 1'b0;
        tick();
        #2;
        n_cmp++;
        if (obs !== exp_vec()) begin
            n_bad++;
            $display("FAIL reset_bypass: got %b want %b", obs, exp_vec());
        end
    endtask

    task automatic test_config_load();
        logic [W-1:0] v;
        v = 12'b101101101101;
        config_en = 1'b1;
        for (int k = 0; k < W; k++) begin
            ccff_head = v[W-1-k];
            #2;
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_bad++;
                $display("FAIL cfg_shift[%0d]: got %b want %b",
                    k, obs, exp_vec());
            end
            tick();
        end
        config_en = 1'b0;
        pad_a2f = 4'b0011; io_f2a_i = 4'b1001;
        #2;
        n_cmp++;
        if (config_loaded !== 1'b1 || f2a_o !== 4'b1001) begin
            n_bad++;
            $display("FAIL cfg_loaded: got ld=%b f2a=%b want 1 1001",
                config_loaded, f2a_o);
        end
        tick();
        #2;
        n_cmp++;
        if (io_a2f_o !== 4'b1100 || obs !== exp_vec()) begin
            n_bad++;
            $display("FAIL cfg_a2f_reg_inv: got %b want 1100 (%b)",
                io_a2f_o, exp_vec());
        end
    endtask

    task automatic test_bursts();
        bit hb[15];
        config_en = 1'b1;
        for (int k = 0; k < 7; k++) begin
            ccff_head = 1'($urandom);
            tick();
        end
        config_en = 1'b0;
        #2;
        n_cmp++;
        if (config_loaded !== 1'b0 || obs !== exp_vec()) begin
            n_bad++;
            $display("FAIL short_burst: got ld=%b want 0", config_loaded);
        end
        tick();
        config_en = 1'b1;
        for (int k = 0; k < 15; k++) begin
            hb[k] = 1'($urandom);
            ccff_head = hb[k];
            #2;
            if (k >= W) begin
                n_cmp++;
                if (ccff_tail !== hb[k-W]) begin
                    n_bad++;
                    $display("FAIL tail_latency[%0d]: got %b want %b",
                        k, ccff_tail, hb[k-W]);
                end
            end
            tick();
        end
        config_en = 1'b0;
        #2;
        n_cmp++;
        if (config_loaded !== 1'b1 || ccff_tail !== hb[3]) begin
            n_bad++;
            $display("FAIL long_burst: got ld=%b tail=%b want 1 %b",
                config_loaded, ccff_tail, hb[3]);
        end
        n_cmp++;
        if (obs !== exp_vec()) begin
            n_bad++;
            $display("FAIL long_burst_vec: got %b want %b", obs, exp_vec());
        end
    endtask

    task automatic test_safe();
        logic [W-1:0] v;
        v = 12'b011011011011;
        load_cfg(v);
        pad_a2f = 4'b0101; io_f2a_i = 4'b1010;
        tick();
        pad_a2f = 4'b1111; io_f2a_i = 4'b1111;
        config_en = 1'b1;
        for (int k = 0; k < W; k++) begin
            ccff_head = v[W-1-k];
            #2;
            n_cmp++;
            if (io_a2f_o !== 4'b0000 || f2a_o !== 4'b0000) begin
                n_bad++;
                $display("FAIL safe_force[%0d]: got %b %b want 0000 0000",
                    k, io_a2f_o, f2a_o);
            end
            tick();
        end
        config_en = 1'b0;
        #2;
        n_cmp++;
        if ({io_a2f_o, f2a_o} !== 8'b0101_1010) begin
            n_bad++;
            $display("FAIL safe_hold: got %b %b want 0101 1010",
                io_a2f_o, f2a_o);
        end
    endtask

    task automatic test_scan();
        logic [7:0] pat;
        pat = 8'b01001101;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        load_cfg(12'b011011011011);
        scan_en = 1'b1;
        for (int j = 0; j < 8; j++) begin
            io_sc_in = pat[j];
            #2;
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_bad++;
                $display("FAIL scan_fill[%0d]: got %b want %b",
                    j, obs, exp_vec());
            end
            tick();
        end
        config_en = 1'b1;
        io_sc_in = 1'b1;
        for (int j = 0; j < 2; j++) begin
            ccff_head = 1'($urandom);
            tick();
        end
        config_en = 1'b0;
        for (int j = 8; j < 16; j++) begin
            io_sc_in = 1'b0;
            #2;
            n_cmp++;
            if (io_sc_out !== pat[j-8] || obs !== exp_vec()) begin
                n_bad++;
                $display("FAIL scan_out[%0d]: got %b want %b",
                    j, io_sc_out, pat[j-8]);
            end
            tick();
        end
        scan_en = 1'b0;
    endtask

    task automatic test_reset_mid_config();
        config_en = 1'b1;
        ccff_head = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        config_en = 1'b0;
        pad_a2f = 4'($urandom); io_f2a_i = 4'($urandom);
        #2;
        n_cmp++;
        if (obs !== {pad_a2f, io_f2a_i, 3'b000}) begin
            n_bad++;
            $display("FAIL mid_reset: got %b want %b",
                obs, {pad_a2f, io_f2a_i, 3'b000});
        end
        load_cfg(12'($urandom));
        #2;
        n_cmp++;
        if (config_loaded !== 1'b1 || obs !== exp_vec()) begin
            n_bad++;
            $display("FAIL reload_after_reset: got %b want %b",
                obs, exp_vec());
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            reset     = ($urandom_range(0, 49) == 0);
            config_en = ($urandom_range(0, 9) < 3);
            scan_en   = ($urandom_range(0, 9) < 3);
            ccff_head = 1'($urandom);
            io_sc_in  = 1'($urandom);
            pad_a2f   = 4'($urandom);
            io_f2a_i  = 4'($urandom);
            #2;
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_bad++;
                $display("FAIL random[%0d]: got %b want %b",
                    c, obs, exp_vec());
            end
            tick();
        end
        reset = 1'b0; config_en = 1'b0; scan_en = 1'b0;
    endtask

    initial begin
        burst = 0;
        en_prev = 1'b0;
        test_reset();
        test_config_load();
        test_bursts();
        test_safe();
        test_scan();
        test_reset_mid_config();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
            n_cmp, n_bad);
        $finish;
    end

endmodule
